// File: rtl/servile_arb_pkg.sv
// Shared definitions for the Servile memory-port arbiter.
package servile_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_e;

    localparam int unsigned ARB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/servile_arb_wdog.sv
// Per-transaction watchdog: saturating wait counter that flags the cycle in
// which a granted access has waited timeout cycles without an ack.
module servile_arb_wdog
    import servile_arb_pkg::*;
#(
    parameter int unsigned timeout = ARB_DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expire
);

    localparam int unsigned   W     = (timeout == 0) ? 1 : $clog2(timeout + 1);
    localparam logic [W-1:0]  LIMIT = W'((timeout == 0) ? 0 : timeout - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear while idle, count unacked grant cycles, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_run && !i_ack && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (timeout != 0) && i_run && !i_ack && (cnt_q == LIMIT);

endmodule

// File: rtl/servile_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing the Servile memory port between the
// CPU (master 0) and a DMA/loader (master 1), with a stall watchdog.
module servile_mem_arbiter
    import servile_arb_pkg::*;
#(
    parameter int unsigned timeout     = ARB_DEFAULT_TIMEOUT,
    parameter logic [31:0] timeout_rdt = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_m0_adr,
    input  logic [31:0] i_wb_m0_dat,
    input  logic [3:0]  i_wb_m0_sel,
    input  logic        i_wb_m0_we,
    input  logic        i_wb_m0_stb,
    output logic [31:0] o_wb_m0_rdt,
    output logic        o_wb_m0_ack,
    input  logic [31:0] i_wb_m1_adr,
    input  logic [31:0] i_wb_m1_dat,
    input  logic [3:0]  i_wb_m1_sel,
    input  logic        i_wb_m1_we,
    input  logic        i_wb_m1_stb,
    output logic [31:0] o_wb_m1_rdt,
    output logic        o_wb_m1_ack,
    output logic [31:0] o_wb_mem_adr,
    output logic [31:0] o_wb_mem_dat,
    output logic [3:0]  o_wb_mem_sel,
    output logic        o_wb_mem_we,
    output logic        o_wb_mem_stb,
    input  logic [31:0] i_wb_mem_rdt,
    input  logic        i_wb_mem_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    output logic        o_timeout_sticky
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;
    logic       sticky_q;
    logic       expire;
    logic       in_grant;
    logic       forced;

    assign in_grant = (state_q == ARB_G0) || (state_q == ARB_G1);
    // A reset cycle never completes anything, forced or real.
    assign forced   = expire && !i_rst;

    servile_arb_wdog #(
        .timeout (timeout)
    ) u_wdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (state_q == ARB_IDLE),
        .i_run    (in_grant),
        .i_ack    (i_wb_mem_ack),
        .o_expire (expire)
    );

    // Next-state: pick an owner from IDLE (tie goes to the non-last master),
    // and return to IDLE on ack, dropped stb or watchdog expiry.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_wb_m0_stb && (!i_wb_m1_stb || last_q)) begin
                    state_d = ARB_G0;
                    last_d  = 1'b0;
                end else if (i_wb_m1_stb) begin
                    state_d = ARB_G1;
                    last_d  = 1'b1;
                end
            end
            ARB_G0: begin
                if (i_wb_mem_ack || expire || !i_wb_m0_stb) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_G1: begin
                if (i_wb_mem_ack || expire || !i_wb_m1_stb) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        grant_d = {state_d == ARB_G1, state_d == ARB_G0};
    end

    // FSM and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ARB_IDLE;
            last_q   <= 1'b1;
            grant_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            if (forced) begin
                sticky_q <= 1'b1;
            end
        end
    end

    // Forward the owner's request to memory and route the response back;
    // a forced completion substitutes the timeout data and withholds stb.
    always_comb begin
        o_wb_mem_adr = '0;
        o_wb_mem_dat = '0;
        o_wb_mem_sel = '0;
        o_wb_mem_we  = 1'b0;
        o_wb_mem_stb = 1'b0;
        o_wb_m0_rdt  = '0;
        o_wb_m0_ack  = 1'b0;
        o_wb_m1_rdt  = '0;
        o_wb_m1_ack  = 1'b0;
        case (state_q)
            ARB_G0: begin
                o_wb_mem_adr = i_wb_m0_adr;
                o_wb_mem_dat = i_wb_m0_dat;
                o_wb_mem_sel = i_wb_m0_sel;
                o_wb_mem_we  = i_wb_m0_we;
                o_wb_mem_stb = i_wb_m0_stb && !expire && !i_rst;
                o_wb_m0_ack  = (i_wb_mem_ack || expire) && !i_rst;
                o_wb_m0_rdt  = expire ? timeout_rdt : i_wb_mem_rdt;
            end
            ARB_G1: begin
                o_wb_mem_adr = i_wb_m1_adr;
                o_wb_mem_dat = i_wb_m1_dat;
                o_wb_mem_sel = i_wb_m1_sel;
                o_wb_mem_we  = i_wb_m1_we;
                o_wb_mem_stb = i_wb_m1_stb && !expire && !i_rst;
                o_wb_m1_ack  = (i_wb_mem_ack || expire) && !i_rst;
                o_wb_m1_rdt  = expire ? timeout_rdt : i_wb_mem_rdt;
            end
            default: ;
        endcase
    end

    assign o_grant          = grant_q;
    assign o_timeout        = forced;
    assign o_timeout_sticky = sticky_q;

endmodule

// File: tb/tb_servile_mem_arbiter.sv
// Self-checking bench for servile_mem_arbiter (watchdog shortened to 8 cycles).
module tb_servile_mem_arbiter;

    localparam int unsigned TMO  = 8;
    localparam logic [31:0] TRDT = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, mem_rdt;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m1_we, m1_stb, mem_ack;
    logic [31:0] m0_rdt, m1_rdt, mem_adr, mem_dat;
    logic [3:0]  mem_sel;
    logic        m0_ack, m1_ack, mem_we, mem_stb, tmo, sticky;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servile_mem_arbiter #(
        .timeout     (TMO),
        .timeout_rdt (TRDT)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wb_m0_adr      (m0_adr),
        .i_wb_m0_dat      (m0_dat),
        .i_wb_m0_sel      (m0_sel),
        .i_wb_m0_we       (m0_we),
        .i_wb_m0_stb      (m0_stb),
        .o_wb_m0_rdt      (m0_rdt),
        .o_wb_m0_ack      (m0_ack),
        .i_wb_m1_adr      (m1_adr),
        .i_wb_m1_dat      (m1_dat),
        .i_wb_m1_sel      (m1_sel),
        .i_wb_m1_we       (m1_we),
        .i_wb_m1_stb      (m1_stb),
        .o_wb_m1_rdt      (m1_rdt),
        .o_wb_m1_ack      (m1_ack),
        .o_wb_mem_adr     (mem_adr),
        .o_wb_mem_dat     (mem_dat),
        .o_wb_mem_sel     (mem_sel),
        .o_wb_mem_we      (mem_we),
        .o_wb_mem_stb     (mem_stb),
        .i_wb_mem_rdt     (mem_rdt),
        .i_wb_mem_ack     (mem_ack),
        .o_grant          (grant),
        .o_timeout        (tmo),
        .o_timeout_sticky (sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 nobody, else master index; waited: unacked cycles so far in
    // this transaction; prefer: master that wins a simultaneous request.
    int owner  = -1;
    int waited = 0;
    int prefer = 0;
    bit stk    = 1'b0;

    logic [1:0]  p_grant;
    logic        p_stb, p_we, p_ack0, p_ack1, p_tmo, p_raw;
    logic [31:0] p_adr, p_dat, p_rdt0, p_rdt1;
    logic [3:0]  p_sel;

    task model_predict();
        logic        stb_x;
        p_grant = '0; p_stb = 0; p_we = 0; p_ack0 = 0; p_ack1 = 0; p_tmo = 0;
        p_adr = '0; p_dat = '0; p_rdt0 = '0; p_rdt1 = '0; p_sel = '0;
        p_raw = (owner >= 0) && !mem_ack && (waited == int'(TMO) - 1);
        if (owner >= 0) begin
            p_grant = (owner == 0) ? 2'b01 : 2'b10;
            stb_x   = (owner == 0) ? m0_stb : m1_stb;
            p_adr   = (owner == 0) ? m0_adr : m1_adr;
            p_dat   = (owner == 0) ? m0_dat : m1_dat;
            p_sel   = (owner == 0) ? m0_sel : m1_sel;
            p_we    = (owner == 0) ? m0_we  : m1_we;
            p_stb   = stb_x && !p_raw && !rst;
            p_tmo   = p_raw && !rst;
            if (owner == 0) begin
                p_ack0 = (mem_ack || p_raw) && !rst;
                p_rdt0 = p_raw ? TRDT : mem_rdt;
            end else begin
                p_ack1 = (mem_ack || p_raw) && !rst;
                p_rdt1 = p_raw ? TRDT : mem_rdt;
            end
        end
    endtask

    task model_step();
        logic stb_x;
        model_predict();
        if (rst) begin
            owner = -1; waited = 0; prefer = 0; stk = 1'b0;
        end else if (owner < 0) begin
            if (m0_stb && m1_stb) owner = prefer;
            else if (m0_stb)      owner = 0;
            else if (m1_stb)      owner = 1;
            if (owner >= 0) begin
                prefer = 1 - owner;
                waited = 0;
            end
        end else begin
            stb_x = (owner == 0) ? m0_stb : m1_stb;
            stk   = stk | p_raw;
            if (mem_ack || p_raw || !stb_x) owner = -1;
            else waited++;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst, s0, s1, ack;
        logic [31:0] rdt;
        logic [1:0]  grant;
        logic        stb, ack0, ack1;
        logic [31:0] rdt0, rdt1, adr, dat;
        logic [3:0]  sel;
        logic        we, tmo;
    } vec_t;

    function automatic vec_t mk(logic r, logic s0, logic s1, logic a, logic [31:0] rd,
                                logic [1:0] g, logic st, logic a0, logic a1,
                                logic [31:0] r0, logic [31:0] r1, logic [31:0] ad,
                                logic [31:0] dt, logic [3:0] sl, logic w, logic t);
        vec_t v;
        v.rst = r; v.s0 = s0; v.s1 = s1; v.ack = a; v.rdt = rd; v.grant = g; v.stb = st;
        v.ack0 = a0; v.ack1 = a1; v.rdt0 = r0; v.rdt1 = r1; v.adr = ad; v.dat = dt;
        v.sel = sl; v.we = w; v.tmo = t;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int pulses;
        bit a0p, a1p;

        rst = 1; m0_stb = 0; m1_stb = 0; mem_ack = 0; mem_rdt = '0;
        m0_adr = 32'h100; m0_dat = '0; m0_sel = 4'hF; m0_we = 0;
        m1_adr = 32'h40; m1_dat = 32'hA5A5A5A5; m1_sel = 4'hF; m1_we = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        settle();
        chk("rst_sticky", sticky, 0);
        chk("rst_grant", grant, 0);

        //            rst s0 s1 ack rdt           grant stb a0 a1 rdt0          rdt1          adr      dat           sel  we tmo
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h0,        32'h0,        32'h100, 32'h0,        4'hF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h12345678, 2'b01, 1, 1, 0, 32'h12345678, 32'h0,        32'h100, 32'h0,        4'hF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0,        2'b10, 1, 0, 1, 32'h0,        32'h0,        32'h40,  32'hA5A5A5A5, 4'hF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h11,       2'b01, 1, 1, 0, 32'h11,       32'h0,        32'h100, 32'h0,        4'hF, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h22,       2'b10, 1, 0, 1, 32'h0,        32'h22,       32'h40,  32'hA5A5A5A5, 4'hF, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h33,       2'b01, 1, 1, 0, 32'h33,       32'h0,        32'h100, 32'h0,        4'hF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        4'h0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; m0_stb = tbl[i].s0; m1_stb = tbl[i].s1;
            mem_ack = tbl[i].ack; mem_rdt = tbl[i].rdt;
            settle();
            chk($sformatf("v%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("v%0d_stb", i), mem_stb, tbl[i].stb);
            chk($sformatf("v%0d_ack0", i), m0_ack, tbl[i].ack0);
            chk($sformatf("v%0d_ack1", i), m1_ack, tbl[i].ack1);
            chk($sformatf("v%0d_rdt0", i), m0_rdt, tbl[i].rdt0);
            chk($sformatf("v%0d_rdt1", i), m1_rdt, tbl[i].rdt1);
            chk($sformatf("v%0d_adr", i), mem_adr, tbl[i].adr);
            chk($sformatf("v%0d_dat", i), mem_dat, tbl[i].dat);
            chk($sformatf("v%0d_sel", i), mem_sel, tbl[i].sel);
            chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d_tmo", i), tmo, tbl[i].tmo);
            advance();
        end
        rst = 0; mem_ack = 0; mem_rdt = '0;

        // Real ack in the would-be expiry cycle wins.
        m0_stb = 1;
        settle();
        chk("aoe_idle", grant, 2'b00);
        advance();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin mem_ack = 1; mem_rdt = 32'h1; end
            settle();
            chk($sformatf("aoe_grant%0d", i), grant, 2'b01);
            chk($sformatf("aoe_tmo%0d", i), tmo, 0);
            if (i < 8) chk($sformatf("aoe_ack%0d", i), m0_ack, 0);
            else begin
                chk("aoe_ack8", m0_ack, 1);
                chk("aoe_rdt8", m0_rdt, 32'h1);
            end
            advance();
        end
        m0_stb = 0; mem_ack = 0; mem_rdt = '0;
        settle();
        chk("aoe_sticky", sticky, 0);
        advance();

        // Memory never acks: forced completion on the 8th grant cycle.
        m0_stb = 1;
        settle();
        advance();
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            settle();
            pulses += int'(tmo);
            chk($sformatf("wd_grant%0d", i), grant, 2'b01);
            if (i < 8) begin
                chk($sformatf("wd_ack%0d", i), m0_ack, 0);
                chk($sformatf("wd_stb%0d", i), mem_stb, 1);
            end else begin
                chk("wd_ack8", m0_ack, 1);
                chk("wd_rdt8", m0_rdt, TRDT);
                chk("wd_stb8", mem_stb, 0);
                chk("wd_tmo8", tmo, 1);
            end
            advance();
        end
        m0_stb = 0;
        settle();
        chk("wd_pulses", pulses, 1);
        chk("wd_after_grant", grant, 2'b00);
        chk("wd_after_tmo", tmo, 0);
        chk("wd_sticky", sticky, 1);
        advance();
        settle();
        chk("wd_sticky_hold", sticky, 1);
        advance();

        // Reset on the 2nd GRANT1 cycle drops the pending ack.
        m1_stb = 1;
        settle();
        advance();
        settle();
        chk("rg_g1_first", grant, 2'b10);
        advance();
        rst = 1; mem_ack = 1; mem_rdt = 32'h77;
        settle();
        chk("rg_ack_dropped", m1_ack, 0);
        advance();
        rst = 0; mem_ack = 0; mem_rdt = '0;
        settle();
        chk("rg_grant", grant, 2'b00);
        chk("rg_stb", mem_stb, 0);
        chk("rg_ack1", m1_ack, 0);
        chk("rg_sticky_clr", sticky, 0);
        advance();
        mem_ack = 1; mem_rdt = 32'hCAFE;
        settle();
        chk("rg_regrant", grant, 2'b10);
        chk("rg_reack", m1_ack, 1);
        chk("rg_rerdt", m1_rdt, 32'hCAFE);
        advance();
        m1_stb = 0; mem_ack = 0;

        // Randomized traffic against the model.
        rst = 1;
        settle();
        advance();
        rst = 0;
        a0p = 0; a1p = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (m0_stb && !a0p) m0_stb = ($urandom_range(0, 29) != 0);
            else begin
                m0_stb = ($urandom_range(0, 1) == 0);
                m0_adr = $urandom; m0_dat = $urandom;
                m0_sel = 4'($urandom); m0_we = 1'($urandom);
            end
            if (m1_stb && !a1p) m1_stb = ($urandom_range(0, 29) != 0);
            else begin
                m1_stb = ($urandom_range(0, 1) == 0);
                m1_adr = $urandom; m1_dat = $urandom;
                m1_sel = 4'($urandom); m1_we = 1'($urandom);
            end
            mem_ack = ($urandom_range(0, 9) < 2);
            mem_rdt = $urandom;
            settle();
            model_predict();
            chk("rnd_grant", grant, p_grant);
            chk("rnd_stb", mem_stb, p_stb);
            chk("rnd_adr", mem_adr, p_adr);
            chk("rnd_dat", mem_dat, p_dat);
            chk("rnd_sel", mem_sel, p_sel);
            chk("rnd_we", mem_we, p_we);
            chk("rnd_ack0", m0_ack, p_ack0);
            chk("rnd_ack1", m1_ack, p_ack1);
            chk("rnd_rdt0", m0_rdt, p_rdt0);
            chk("rnd_rdt1", m1_rdt, p_rdt1);
            chk("rnd_tmo", tmo, p_tmo);
            chk("rnd_sticky", sticky, stk);
            a0p = p_ack0; a1p = p_ack1;
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
